// File: rtl/execute_branch_condition_pkg.sv
// Shared flag layout and condition-code encoding for the execute branch path.
package execute_branch_condition_pkg;

    // Flag bit positions, shared with the flag register.
    localparam int FLAG_W = 5;
    localparam int FLAG_Z = 0;
    localparam int FLAG_P = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 4;

    typedef enum logic [3:0] {
        CC_ALWAYS = 4'd0,
        CC_EQ     = 4'd1,
        CC_NE     = 4'd2,
        CC_CS     = 4'd3,
        CC_CC     = 4'd4,
        CC_MI     = 4'd5,
        CC_PL     = 4'd6,
        CC_VS     = 4'd7,
        CC_VC     = 4'd8,
        CC_HI     = 4'd9,
        CC_LS     = 4'd10,
        CC_GE     = 4'd11,
        CC_LT     = 4'd12,
        CC_GT     = 4'd13,
        CC_LE     = 4'd14,
        CC_PE     = 4'd15
    } cc_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/execute_branch_condition_cond_eval.sv
// Combinational condition-code evaluator: flags + cc -> taken.
module branch_cond_eval
    import execute_branch_condition_pkg::*;
(
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [3:0]        cc_i,
    output logic              taken_o
);

    logic z, p, c, o, s;

    assign z = flags_i[FLAG_Z];
    assign p = flags_i[FLAG_P];
    assign c = flags_i[FLAG_C];
    assign o = flags_i[FLAG_O];
    assign s = flags_i[FLAG_S];

    // Decode the condition code against the individual flags.
    always_comb begin
        taken_o = 1'b0;
        case (cc_e'(cc_i))
            CC_ALWAYS: taken_o = 1'b1;
            CC_EQ:     taken_o = z;
            CC_NE:     taken_o = ~z;
            CC_CS:     taken_o = c;
            CC_CC:     taken_o = ~c;
            CC_MI:     taken_o = s;
            CC_PL:     taken_o = ~s;
            CC_VS:     taken_o = o;
            CC_VC:     taken_o = ~o;
            CC_HI:     taken_o = c & ~z;
            CC_LS:     taken_o = ~c | z;
            CC_GE:     taken_o = (s == o);
            CC_LT:     taken_o = (s != o);
            CC_GT:     taken_o = ~z & (s == o);
            CC_LE:     taken_o = z | (s != o);
            CC_PE:     taken_o = p;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_branch_condition.sv
// Execute-stage branch resolver: evaluates the condition on current or
// forwarded flags, registers the redirect, and drains wrong-path instructions.
module execute_branch_condition
    import execute_branch_condition_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic              iRESET_SYNC,
    input  logic              iCTRL_HOLD,
    input  logic              iPREV_VALID,
    output logic              oPREV_BUSY,
    input  logic              iPREV_BRANCH,
    input  logic [3:0]        iPREV_CC,
    input  logic [PC_W-1:0]   iPREV_PC,
    input  logic [PC_W-1:0]   iPREV_TARGET,
    input  logic [FLAG_W-1:0] iFLAG,
    input  logic              iFLAG_FWD_VALID,
    input  logic [FLAG_W-1:0] iFLAG_FWD,
    output logic              oNEXT_VALID,
    input  logic              iNEXT_BUSY,
    output logic              oNEXT_TAKEN,
    output logic [PC_W-1:0]   oNEXT_PC,
    output logic [PC_W-1:0]   oNEXT_JUMP_ADDR,
    output logic              oFLUSH
);

    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    drain_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              taken_q, taken_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   jump_q, jump_d;
    logic              flush_q, flush_d;

    logic [FLAG_W-1:0] eff_flags;
    logic              cond_taken;
    logic              br_taken;
    logic              accept;

    // A flag write in the same cycle overrides the architectural value.
    assign eff_flags = iFLAG_FWD_VALID ? iFLAG_FWD : iFLAG;

    branch_cond_eval u_cond_eval (
        .flags_i (eff_flags),
        .cc_i    (iPREV_CC),
        .taken_o (cond_taken)
    );

    assign br_taken   = iPREV_BRANCH & cond_taken;
    assign oPREV_BUSY = iCTRL_HOLD | (valid_q & iNEXT_BUSY);
    assign accept     = iPREV_VALID & ~oPREV_BUSY & ~iCTRL_HOLD;

    // Next-state: load result in RUN, count down discarded accepts in DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q & iNEXT_BUSY;
        taken_d = taken_q;
        pc_d    = pc_q;
        jump_d  = jump_q;
        flush_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    valid_d = 1'b1;
                    taken_d = br_taken;
                    pc_d    = iPREV_PC;
                    jump_d  = br_taken ? iPREV_TARGET : iPREV_PC + PC_STEP;
                    if (br_taken) begin
                        state_d = ST_DRAIN;
                        cnt_d   = FLUSH_INIT;
                        flush_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers; sync clear beats hold, hold freezes everything else.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            pc_q    <= '0;
            jump_q  <= '0;
            flush_q <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            pc_q    <= '0;
            jump_q  <= '0;
            flush_q <= 1'b0;
        end else if (!iCTRL_HOLD) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            pc_q    <= pc_d;
            jump_q  <= jump_d;
            flush_q <= flush_d;
        end
    end

    assign oNEXT_VALID     = valid_q;
    assign oNEXT_TAKEN     = taken_q;
    assign oNEXT_PC        = pc_q;
    assign oNEXT_JUMP_ADDR = jump_q;
    assign oFLUSH          = flush_q;

endmodule

// File: tb/tb_execute_branch_condition.sv
// Bench for execute_branch_condition: directed scenarios plus a randomized
// run against a behavioural model.
module tb_execute_branch_condition;

    localparam int PC_W  = 32;
    localparam int FLUSH = 2;

    logic            iCLOCK = 1'b0;
    logic            iRESET, iRESET_SYNC, iCTRL_HOLD;
    logic            iPREV_VALID, oPREV_BUSY, iPREV_BRANCH;
    logic [3:0]      iPREV_CC;
    logic [PC_W-1:0] iPREV_PC, iPREV_TARGET;
    logic [4:0]      iFLAG, iFLAG_FWD;
    logic            iFLAG_FWD_VALID;
    logic            oNEXT_VALID, iNEXT_BUSY, oNEXT_TAKEN, oFLUSH;
    logic [PC_W-1:0] oNEXT_PC, oNEXT_JUMP_ADDR;

    int checks   = 0;
    int failures = 0;

    execute_branch_condition #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
        .iCTRL_HOLD(iCTRL_HOLD), .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(oPREV_BUSY),
        .iPREV_BRANCH(iPREV_BRANCH), .iPREV_CC(iPREV_CC), .iPREV_PC(iPREV_PC),
        .iPREV_TARGET(iPREV_TARGET), .iFLAG(iFLAG), .iFLAG_FWD_VALID(iFLAG_FWD_VALID),
        .iFLAG_FWD(iFLAG_FWD), .oNEXT_VALID(oNEXT_VALID), .iNEXT_BUSY(iNEXT_BUSY),
        .oNEXT_TAKEN(oNEXT_TAKEN), .oNEXT_PC(oNEXT_PC),
        .oNEXT_JUMP_ADDR(oNEXT_JUMP_ADDR), .oFLUSH(oFLUSH)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Condition table written out from the flag meanings.
    function automatic bit ref_cond(input int cc, input bit [4:0] f);
        bit z, p, c, o, s;
        z = f[0]; p = f[1]; c = f[2]; o = f[3]; s = f[4];
        case (cc)
            0:  return 1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return s;
            6:  return !s;
            7:  return o;
            8:  return !o;
            9:  return c && !z;
            10: return !c || z;
            11: return s == o;
            12: return s != o;
            13: return !z && (s == o);
            14: return z || (s != o);
            default: return p;
        endcase
    endfunction

    task automatic tick;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle;
        iCTRL_HOLD = 0; iPREV_VALID = 0; iPREV_BRANCH = 0; iPREV_CC = 0;
        iPREV_PC = 0; iPREV_TARGET = 0; iFLAG = 0; iFLAG_FWD_VALID = 0;
        iFLAG_FWD = 0; iNEXT_BUSY = 0;
    endtask

    task automatic sync_clear;
        idle();
        iRESET_SYNC = 1;
        tick();
        iRESET_SYNC = 0;
    endtask

    task automatic drive(input bit br, input int cc, input logic [PC_W-1:0] pc,
                         input logic [PC_W-1:0] tgt, input logic [4:0] fl);
        iPREV_VALID = 1; iPREV_BRANCH = br; iPREV_CC = 4'(cc);
        iPREV_PC = pc; iPREV_TARGET = tgt; iFLAG = fl;
    endtask

    task automatic test_reset;
        idle();
        iRESET = 1; iRESET_SYNC = 0;
        #1;
        checks++;
        if ({oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_PC, oNEXT_JUMP_ADDR} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b t=%b f=%b pc=%h j=%h required all zero",
                     oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_PC, oNEXT_JUMP_ADDR);
        end
        tick();
        iRESET = 0;
        tick();
    endtask

    task automatic test_eq_taken;
        sync_clear();
        drive(1, 1, 32'h100, 32'h200, 5'b00001);
        tick();
        iPREV_VALID = 0;
        checks++;
        if ({oNEXT_VALID, oNEXT_TAKEN, oFLUSH} !== 3'b111 || oNEXT_JUMP_ADDR !== 32'h200 ||
            oNEXT_PC !== 32'h100) begin
            failures++;
            $display("FAIL eq_taken got v=%b t=%b f=%b pc=%h j=%h required 1 1 1 100 200",
                     oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_PC, oNEXT_JUMP_ADDR);
        end
        tick();
        checks++;
        if (oFLUSH !== 1'b0 || oNEXT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL eq_flush_one_cycle got f=%b v=%b required 0 0", oFLUSH, oNEXT_VALID);
        end
    endtask

    task automatic test_fwd;
        sync_clear();
        drive(1, 1, 32'h100, 32'h200, 5'b00001);
        iFLAG_FWD_VALID = 1; iFLAG_FWD = 5'b00000;
        tick();
        idle();
        checks++;
        if (oNEXT_VALID !== 1'b1 || oNEXT_TAKEN !== 1'b0 || oFLUSH !== 1'b0 ||
            oNEXT_JUMP_ADDR !== 32'h104) begin
            failures++;
            $display("FAIL fwd_wins got v=%b t=%b f=%b j=%h required 1 0 0 104",
                     oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_JUMP_ADDR);
        end
    endtask

    task automatic test_drain;
        sync_clear();
        drive(1, 0, 32'h80, 32'h300, 5'b0);
        tick();
        drive(0, 0, 32'h10, 32'h0, 5'b0);
        tick();
        checks++;
        if (oNEXT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL drain_discard1 got v=%b required 0", oNEXT_VALID);
        end
        drive(1, 0, 32'h14, 32'h500, 5'b0);
        tick();
        checks++;
        if (oNEXT_VALID !== 1'b0 || oFLUSH !== 1'b0) begin
            failures++;
            $display("FAIL drain_discard2 got v=%b f=%b required 0 0", oNEXT_VALID, oFLUSH);
        end
        drive(0, 0, 32'h18, 32'h0, 5'b0);
        tick();
        idle();
        checks++;
        if (oNEXT_VALID !== 1'b1 || oNEXT_PC !== 32'h18 || oNEXT_JUMP_ADDR !== 32'h1c) begin
            failures++;
            $display("FAIL drain_third got v=%b pc=%h j=%h required 1 18 1c",
                     oNEXT_VALID, oNEXT_PC, oNEXT_JUMP_ADDR);
        end
    endtask

    task automatic test_cond_table;
        bit exp;
        for (int f = 0; f < 32; f++) begin
            sync_clear();
            drive(1, 13, 32'h400, 32'h800, 5'(f));
            tick();
            exp = ref_cond(13, 5'(f));
            checks++;
            if (oNEXT_TAKEN !== exp || oFLUSH !== exp) begin
                failures++;
                $display("FAIL cc_gt flags=%b got t=%b f=%b required %b", 5'(f),
                         oNEXT_TAKEN, oFLUSH, exp);
            end
        end
        sync_clear();
        drive(1, 12, 32'h400, 32'h800, 5'b10000);
        tick();
        checks++;
        if (oNEXT_TAKEN !== 1'b1 || oNEXT_JUMP_ADDR !== 32'h800) begin
            failures++;
            $display("FAIL cc_lt got t=%b j=%h required 1 800", oNEXT_TAKEN, oNEXT_JUMP_ADDR);
        end
        idle();
    endtask

    task automatic test_back_to_back_busy;
        sync_clear();
        drive(0, 0, 32'h20, 32'h0, 5'b0);
        tick();
        drive(0, 0, 32'h24, 32'h0, 5'b0);
        iNEXT_BUSY = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (oPREV_BUSY !== 1'b1 || oNEXT_VALID !== 1'b1 || oNEXT_PC !== 32'h20) begin
                failures++;
                $display("FAIL busy_hold cyc=%0d got busy=%b v=%b pc=%h required 1 1 20",
                         i, oPREV_BUSY, oNEXT_VALID, oNEXT_PC);
            end
            tick();
        end
        iNEXT_BUSY = 0;
        #1;
        checks++;
        if (oPREV_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL busy_release got busy=%b required 0", oPREV_BUSY);
        end
        tick();
        idle();
        checks++;
        if (oNEXT_VALID !== 1'b1 || oNEXT_PC !== 32'h24) begin
            failures++;
            $display("FAIL busy_reload got v=%b pc=%h required 1 24", oNEXT_VALID, oNEXT_PC);
        end
    endtask

    task automatic test_async_reset_mid_drain;
        sync_clear();
        drive(1, 0, 32'h100, 32'h200, 5'b0);
        tick();
        drive(0, 0, 32'h40, 32'h0, 5'b0);
        tick();
        idle();
        #2;
        iRESET = 1;
        #1;
        checks++;
        if ({oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_PC, oNEXT_JUMP_ADDR} !== '0) begin
            failures++;
            $display("FAIL async_reset got v=%b t=%b f=%b pc=%h j=%h required all zero",
                     oNEXT_VALID, oNEXT_TAKEN, oFLUSH, oNEXT_PC, oNEXT_JUMP_ADDR);
        end
        #1;
        iRESET = 0;
        drive(1, 1, 32'hFFFF_FFFC, 32'h1234, 5'b0);
        tick();
        idle();
        checks++;
        if (oNEXT_VALID !== 1'b1 || oNEXT_TAKEN !== 1'b0 || oNEXT_JUMP_ADDR !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_wrap got v=%b t=%b j=%h required 1 0 0",
                     oNEXT_VALID, oNEXT_TAKEN, oNEXT_JUMP_ADDR);
        end
    endtask

    task automatic test_hold_flush;
        sync_clear();
        drive(1, 0, 32'h60, 32'h90, 5'b0);
        tick();
        drive(0, 0, 32'h64, 32'h0, 5'b0);
        iCTRL_HOLD = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (oPREV_BUSY !== 1'b1) begin
                failures++;
                $display("FAIL hold_busy got %b required 1", oPREV_BUSY);
            end
            tick();
            checks++;
            if (oFLUSH !== 1'b1 || oNEXT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL hold_freeze cyc=%0d got f=%b v=%b required 1 1",
                         i, oFLUSH, oNEXT_VALID);
            end
        end
        iCTRL_HOLD = 0; iPREV_VALID = 0;
        tick();
        checks++;
        if (oFLUSH !== 1'b0) begin
            failures++;
            $display("FAIL hold_release_flush got %b required 0", oFLUSH);
        end
        drive(0, 0, 32'h70, 32'h0, 5'b0);
        iCTRL_HOLD = 1; iRESET_SYNC = 1;
        tick();
        iRESET_SYNC = 0;
        idle();
        checks++;
        if (oNEXT_VALID !== 1'b0 || oNEXT_TAKEN !== 1'b0 || oNEXT_PC !== 32'h0) begin
            failures++;
            $display("FAIL sync_over_hold got v=%b t=%b pc=%h required 0 0 0",
                     oNEXT_VALID, oNEXT_TAKEN, oNEXT_PC);
        end
    endtask

    task automatic test_random;
        bit              m_valid, m_taken, m_flush, tk, busy, acc;
        logic [PC_W-1:0] m_pc, m_jump;
        logic [4:0]      fl;
        int              m_drain;
        sync_clear();
        m_valid = 0; m_taken = 0; m_flush = 0; m_pc = 0; m_jump = 0; m_drain = 0;
        for (int n = 0; n < 400; n++) begin
            iCTRL_HOLD      = ($urandom_range(0, 7) == 0);
            iPREV_VALID     = $urandom_range(0, 3) != 0;
            iPREV_BRANCH    = $urandom_range(0, 1);
            iPREV_CC        = 4'($urandom_range(0, 15));
            iPREV_PC        = $urandom;
            iPREV_TARGET    = $urandom;
            iFLAG           = 5'($urandom_range(0, 31));
            iFLAG_FWD_VALID = $urandom_range(0, 1);
            iFLAG_FWD       = 5'($urandom_range(0, 31));
            iNEXT_BUSY      = $urandom_range(0, 2) == 0;
            busy = iCTRL_HOLD || (m_valid && iNEXT_BUSY);
            acc  = iPREV_VALID && !busy;
            #1;
            checks++;
            if (oPREV_BUSY !== busy) begin
                failures++;
                $display("FAIL rnd_busy n=%0d got %b required %b", n, oPREV_BUSY, busy);
            end
            if (!iCTRL_HOLD) begin
                if (acc && m_drain > 0) begin
                    m_drain--;
                    m_valid = 0;
                    m_flush = 0;
                end else if (acc) begin
                    fl = iFLAG_FWD_VALID ? iFLAG_FWD : iFLAG;
                    tk = iPREV_BRANCH && ref_cond(int'(iPREV_CC), fl);
                    m_valid = 1; m_taken = tk; m_pc = iPREV_PC;
                    m_jump  = tk ? iPREV_TARGET : iPREV_PC + 32'd4;
                    m_flush = tk;
                    if (tk) m_drain = FLUSH;
                end else begin
                    if (!iNEXT_BUSY) m_valid = 0;
                    m_flush = 0;
                end
            end
            tick();
            checks++;
            if (oNEXT_VALID !== m_valid || oFLUSH !== m_flush ||
                (m_valid && (oNEXT_TAKEN !== m_taken || oNEXT_PC !== m_pc ||
                             oNEXT_JUMP_ADDR !== m_jump))) begin
                failures++;
                $display("FAIL rnd_out n=%0d got v=%b f=%b t=%b pc=%h j=%h required v=%b f=%b t=%b pc=%h j=%h",
                         n, oNEXT_VALID, oFLUSH, oNEXT_TAKEN, oNEXT_PC, oNEXT_JUMP_ADDR,
                         m_valid, m_flush, m_taken, m_pc, m_jump);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_eq_taken();
        test_fwd();
        test_drain();
        test_cond_table();
        test_back_to_back_busy();
        test_async_reset_mid_drain();
        test_hold_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_branch_condition.md
Name: execute_branch_condition

Overview:
- Execute-stage branch resolver sitting directly downstream of the execute flag register (consumes its 5-bit flag output plus the same-cycle flag write).
- Evaluates 4-bit condition codes against current or forwarded flags.
- Registers a taken/not-taken result with its jump address toward the fetch redirect logic.
- Pulses a pipeline flush and discards wrong-path instructions for a fixed drain window.

Parameters:
- PC_W, 32, width of PC and branch target.
- FLUSH_CYCLES, 2, number of accepted upstream instructions discarded after a taken branch (1..15).

Ports:
- iCLOCK  in  1  clock.
- iRESET  in  1  asynchronous, active-high reset.
- iRESET_SYNC  in  1  synchronous clear, same effect as iRESET.
- iCTRL_HOLD  in  1  freeze all state; no accept.
- iPREV_VALID  in  1  upstream instruction valid.
- oPREV_BUSY  out  1  backpressure to upstream.
- iPREV_BRANCH  in  1  instruction is a conditional branch.
- iPREV_CC  in  4  condition code.
- iPREV_PC  in  PC_W  instruction PC.
- iPREV_TARGET  in  PC_W  branch target.
- iFLAG  in  5  architectural flags from the flag register.
- iFLAG_FWD_VALID  in  1  flag register is being written this cycle.
- iFLAG_FWD  in  5  value being written.
- oNEXT_VALID  out  1  result valid.
- iNEXT_BUSY  in  1  downstream backpressure.
- oNEXT_TAKEN  out  1  branch taken.
- oNEXT_PC  out  PC_W  PC of the resolved instruction.
- oNEXT_JUMP_ADDR  out  PC_W  target when taken, else PC+4.
- oFLUSH  out  1  one-cycle flush pulse.

Behaviour:
- Flag bit map: [0]=Z, [1]=P (parity), [2]=C, [3]=O (overflow), [4]=S.
- Effective flags: iFLAG_FWD when iFLAG_FWD_VALID=1, else iFLAG. Purely combinational; forward wins.
- Condition codes:
  - 0 ALWAYS, 1 EQ Z, 2 NE !Z, 3 CS C, 4 CC !C.
  - 5 MI S, 6 PL !S, 7 VS O, 8 VC !O.
  - 9 HI C&!Z, 10 LS !C|Z.
  - 11 GE S==O, 12 LT S!=O, 13 GT !Z&(S==O), 14 LE Z|(S!=O).
  - 15 PE P.
- Non-branch instructions (iPREV_BRANCH=0) pass through with taken=0.
- Accept condition: iPREV_VALID & !oPREV_BUSY & !iCTRL_HOLD.
- oPREV_BUSY = iCTRL_HOLD | (oNEXT_VALID & iNEXT_BUSY).
- Latency: 1 cycle. On accept, the output registers load in the next edge and oNEXT_VALID=1.
- Output registers hold while iNEXT_BUSY=1.
- oNEXT_VALID clears when the result is consumed (iNEXT_BUSY=0) with no new accept.
- oNEXT_JUMP_ADDR = taken ? iPREV_TARGET : iPREV_PC+4, computed mod 2^PC_W so wrap-around is silent.
- Drain FSM states:
  - RUN → DRAIN on accept of a taken branch. The drain counter loads FLUSH_CYCLES and oFLUSH registers to 1 for exactly one cycle (coincident with the first cycle oNEXT_VALID shows the branch).
  - In DRAIN, accepted instructions are consumed but discarded: no output load, no flag evaluation, no further flush.
  - The counter decrements per discarded accept. DRAIN → RUN when it reaches 0.
  - Empty upstream cycles do not decrement.
- iCTRL_HOLD=1: all registers frozen, including the counter and oFLUSH. A pending flush pulse is extended until the hold releases, then lasts one cycle.
- Reset (async or sync, including mid-drain): oNEXT_VALID=0, oNEXT_TAKEN=0, oNEXT_PC=0, oNEXT_JUMP_ADDR=0, oFLUSH=0, state RUN, counter 0.
- iRESET_SYNC has priority over iCTRL_HOLD.
- Simultaneous consume and accept: the output reloads with the new instruction in the same edge, giving no bubble.

Decomposition:
- Shared package holds:
  - flag bit index constants (FLAG_Z, FLAG_P, FLAG_C, FLAG_O, FLAG_S), shared with the flag register.
  - the 16 condition-code constants (CC_ALWAYS..CC_PE).
- One natural sub-module: branch_cond_eval, purely combinational, 5-bit flags + 4-bit cc → taken. It is reused by the fetch-side predictor checker.
- The drain FSM and pipeline register stay in the top module.

Test Plan:
- iFLAG=5'b00001 (Z), branch CC=1 EQ, PC=0x100, target 0x200 → next cycle oNEXT_VALID=1, TAKEN=1, JUMP_ADDR=0x200, oFLUSH=1 for one cycle.
- Same branch, but iFLAG_FWD_VALID=1 with iFLAG_FWD=0 in the accept cycle → TAKEN=0, JUMP_ADDR=0x104, no flush.
- Taken branch followed by 3 back-to-back instructions (FLUSH_CYCLES=2) → first two discarded (no oNEXT_VALID), third appears with its own PC.
- CC=13 GT over all 32 flag values and CC=12 LT with S=1, O=0 → taken matches the table for every combination.
- iNEXT_BUSY=1 for 3 cycles while a result is valid → oPREV_BUSY=1, outputs stable; on release, the next instruction loads the following edge.
- Assert iRESET asynchronously mid-drain (counter=1) → all outputs 0 immediately. After release, the first instruction passes (not discarded). PC=0xFFFFFFFC non-taken → JUMP_ADDR=0x0.
